// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// execution-engine opcode values and the 4-bit peripheral select codes that
// occupy address[15:12] on the shared bus.
package ifetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } ifetch_state_e;

  // Matrix ALU opcodes
  localparam logic [7:0] OP_MMULT     = 8'h00;
  localparam logic [7:0] OP_MADD      = 8'h01;
  localparam logic [7:0] OP_MSUB      = 8'h02;
  localparam logic [7:0] OP_MTRANSP   = 8'h03;
  localparam logic [7:0] OP_MSCALE    = 8'h04;
  localparam logic [7:0] OP_MSCALEIMM = 8'h05;
  // Integer ALU opcodes
  localparam logic [7:0] OP_INTADD    = 8'h10;
  localparam logic [7:0] OP_INTSUB    = 8'h11;
  localparam logic [7:0] OP_INTMUL    = 8'h12;
  localparam logic [7:0] OP_INTDIV    = 8'h13;
  // Program terminator
  localparam logic [7:0] OP_STOP      = 8'hFF;

  // Peripheral select codes (address[15:12])
  localparam logic [3:0] SEL_MAINMEM  = 4'b0000;
  localparam logic [3:0] SEL_IMEM     = 4'b1000;
  localparam logic [3:0] SEL_MALU     = 4'b0100;
  localparam logic [3:0] SEL_IALU     = 4'b0101;
  localparam logic [3:0] SEL_REG      = 4'b0010;
  localparam logic [3:0] SEL_EXEC     = 4'b0001;

endpackage

// File: rtl/ifetch_opclass.sv
// ifetch_opclass
// Combinational opcode classifier used by the fetch FSM at the capture edge.
//   opcode_i  : opcode byte of the fetched word
//   is_stop_o : opcode is the Stop terminator (FFh)
//   is_legal_o: opcode may be presented to the execution engine
// Configuration macro IFETCH_OPCHECK_EN: when defined, only 00h-05h and
// 10h-13h are legal; when undefined, every non-Stop opcode is legal, which
// means the fetch unit never raises IllegalOp.
import ifetch_pkg::*;

module ifetch_opclass (
  input  logic [7:0] opcode_i,
  output logic       is_stop_o,
  output logic       is_legal_o
);

  assign is_stop_o = (opcode_i == OP_STOP);

`ifdef IFETCH_OPCHECK_EN
  always_comb begin
    is_legal_o = 1'b0;
    if (opcode_i >= OP_MMULT && opcode_i <= OP_MSCALEIMM) begin
      is_legal_o = 1'b1;
    end else if (opcode_i >= OP_INTADD && opcode_i <= OP_INTDIV) begin
      is_legal_o = 1'b1;
    end else if (opcode_i == OP_STOP) begin
      is_legal_o = 1'b1;
    end
  end
`else
  assign is_legal_o = 1'b1;
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Bus initiator that fetches 32-bit instruction words from instruction memory
// starting at PC 0 after a Start pulse, waits out the memory read latency and
// presents the opcode/dest/src1/src2 bytes to the execution engine with a
// valid/ready handshake. Stops on the Stop opcode or at the end of IMEM.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   Start               : begin fetching at PC 0 (IDLE or HALT only)
//   address, nRead      : registered bus request ({IMEM_SEL, PC}, active-low)
//   DataIn              : memory read data, instruction in [31:0]
//   InstrReady          : execution engine accepts the presented instruction
//   InstrValid, Opcode, Dest, Src1, Src2 : presented instruction
//   Busy, Halted        : status
//   Overrun, IllegalOp  : sticky error flags, cleared by Start
// Configuration macro IFETCH_OPCHECK_EN enables the illegal-opcode check
// (implemented in ifetch_opclass); without it IllegalOp stays 0.
import ifetch_pkg::*;

module instruction_fetch_unit #(
  parameter logic [3:0] IMEM_SEL     = SEL_IMEM,
  parameter int          IMEM_DEPTH   = 10,
  parameter int          READ_LATENCY = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  output logic [15:0]  address,
  output logic         nRead,
  input  logic [255:0] DataIn,
  input  logic         InstrReady,
  output logic         InstrValid,
  output logic [7:0]   Opcode,
  output logic [7:0]   Dest,
  output logic [7:0]   Src1,
  output logic [7:0]   Src2,
  output logic         Busy,
  output logic         Halted,
  output logic         Overrun,
  output logic         IllegalOp
);

  localparam logic [11:0] PC_LAST   = 12'(IMEM_DEPTH - 1);
  // WAIT counts down from READ_LATENCY-1; capture happens when it reads 0.
  localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

  ifetch_state_e state_q, state_d;
  logic [11:0]   pc_q, pc_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic [15:0]   address_q, address_d;
  logic          nread_q, nread_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [7:0]    dest_q, dest_d;
  logic [7:0]    src1_q, src1_d;
  logic [7:0]    src2_q, src2_d;
  logic          overrun_q, overrun_d;
  logic          illegal_q, illegal_d;

  logic          is_stop;
  logic          is_legal;
  logic          data_unused;

  // Only the low word of the wide bus carries the instruction.
  assign data_unused = ^DataIn[255:32];

  ifetch_opclass u_opclass (
    .opcode_i   (DataIn[31:24]),
    .is_stop_o  (is_stop),
    .is_legal_o (is_legal)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    address_d  = address_q;
    nread_d    = 1'b1;
    opcode_d   = opcode_q;
    dest_d     = dest_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    overrun_d  = overrun_q;
    illegal_d  = illegal_q;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          pc_d      = 12'h000;
          overrun_d = 1'b0;
          illegal_d = 1'b0;
          // Request is issued straight from the Start edge.
          address_d = {IMEM_SEL, 12'h000};
          nread_d   = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          if (is_stop) begin
            state_d = ST_HALT;
          end else if (!is_legal) begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            opcode_d = DataIn[31:24];
            dest_d   = DataIn[23:16];
            src1_d   = DataIn[15:8];
            src2_d   = DataIn[7:0];
            state_d  = ST_VALID;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ST_VALID: begin
        if (InstrReady) begin
          // End-of-space check precedes the increment, so PC never wraps.
          if (pc_q == PC_LAST) begin
            overrun_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            pc_d      = pc_q + 12'd1;
            address_d = {IMEM_SEL, pc_q + 12'd1};
            nread_d   = 1'b0;
            state_d   = ST_REQ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= 12'h000;
      wait_cnt_q <= 2'd0;
      address_q  <= 16'h0000;
      nread_q    <= 1'b1;
      opcode_q   <= 8'h00;
      dest_q     <= 8'h00;
      src1_q     <= 8'h00;
      src2_q     <= 8'h00;
      overrun_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      address_q  <= address_d;
      nread_q    <= nread_d;
      opcode_q   <= opcode_d;
      dest_q     <= dest_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      overrun_q  <= overrun_d;
      illegal_q  <= illegal_d;
    end
  end

  assign address    = address_q;
  assign nRead      = nread_q;
  assign InstrValid = (state_q == ST_VALID);
  assign Opcode     = opcode_q;
  assign Dest       = dest_q;
  assign Src1       = src1_q;
  assign Src2       = src2_q;
  assign Busy       = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_VALID);
  assign Halted     = (state_q == ST_HALT);
  assign Overrun    = overrun_q;
  assign IllegalOp  = illegal_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Two instances: u_dut (IMEM_DEPTH 10)
// for program, timing, backpressure, reset and opcode tests; u_dut2
// (IMEM_DEPTH 2) for the overrun test. Each has a registered memory responder
// with one cycle of read latency.
module tb_instruction_fetch_unit;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0, Start2 = 1'b0;
  logic         InstrReady = 1'b0, InstrReady2 = 1'b0;
  logic [255:0] DataIn = '0, DataIn2 = '0;
  logic [15:0]  address, address2;
  logic         nRead, nRead2;
  logic         InstrValid, InstrValid2;
  logic [7:0]   Opcode, Dest, Src1, Src2;
  logic [7:0]   Opcode2, Dest2, Src1_2, Src2_2;
  logic         Busy, Halted, Overrun, IllegalOp;
  logic         Busy2, Halted2, Overrun2, IllegalOp2;

  logic [31:0]  mem  [0:15];
  logic [31:0]  mem2 [0:15];
  logic [15:0]  addr_log[$], addr_log2[$];
  logic [31:0]  acc_log[$],  acc_log2[$];
  bit           seen_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .address(address), .nRead(nRead),
    .DataIn(DataIn), .InstrReady(InstrReady), .InstrValid(InstrValid),
    .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2), .Busy(Busy),
    .Halted(Halted), .Overrun(Overrun), .IllegalOp(IllegalOp)
  );

  instruction_fetch_unit #(.IMEM_DEPTH(2)) u_dut2 (
    .Clk(clk), .Reset(Reset), .Start(Start2), .address(address2), .nRead(nRead2),
    .DataIn(DataIn2), .InstrReady(InstrReady2), .InstrValid(InstrValid2),
    .Opcode(Opcode2), .Dest(Dest2), .Src1(Src1_2), .Src2(Src2_2), .Busy(Busy2),
    .Halted(Halted2), .Overrun(Overrun2), .IllegalOp(IllegalOp2)
  );

  // Registered memory responders, READ_LATENCY = 1
  always @(posedge clk) begin
    if (!nRead)  DataIn  <= {224'h0, mem[address[3:0]]};
    if (!nRead2) DataIn2 <= {224'h0, mem2[address2[3:0]]};
  end

  // Bus / handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!nRead)  addr_log.push_back(address);
    if (!nRead2) addr_log2.push_back(address2);
    if (InstrValid) seen_valid = 1'b1;
    if (InstrValid && InstrReady)   acc_log.push_back({Opcode, Dest, Src1, Src2});
    if (InstrValid2 && InstrReady2) acc_log2.push_back({Opcode2, Dest2, Src1_2, Src2_2});
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !Halted; i++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (address !== 16'h0000 || nRead !== 1'b1) begin
      n_err++;
      $display("FAIL reset_bus: address=%h nRead=%b, required 0000 / 1", address, nRead);
    end
    n_cmp++;
    if ({Opcode, Dest, Src1, Src2} !== 32'h0 || InstrValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fields: fields=%h valid=%b, required 0 / 0",
               {Opcode, Dest, Src1, Src2}, InstrValid);
    end
    n_cmp++;
    if ({Busy, Halted, Overrun, IllegalOp} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_status: BHOI=%b, required 0000", {Busy, Halted, Overrun, IllegalOp});
    end
    $display("test_reset: address=%h nRead=%b status=%b", address, nRead,
             {Busy, Halted, Overrun, IllegalOp});
  endtask

  task automatic test_program();
    do_reset();
    mem[0] = 32'h01020001; mem[1] = 32'h120A0001; mem[2] = 32'hFF000000;
    addr_log.delete(); acc_log.delete();
    InstrReady = 1'b1;
    pulse_start();
    wait_halt(60);
    @(negedge clk);
    n_cmp++;
    if (Halted !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL prog_halt: Halted=%b Busy=%b, required 1 / 0", Halted, Busy);
    end
    n_cmp++;
    if (acc_log.size() != 2) begin
      n_err++;
      $display("FAIL prog_count: accepted=%0d, required 2", acc_log.size());
    end else begin
      n_cmp++;
      if (acc_log[0] !== 32'h01020001 || acc_log[1] !== 32'h120A0001) begin
        n_err++;
        $display("FAIL prog_words: got %h %h, required 01020001 120a0001", acc_log[0], acc_log[1]);
      end
    end
    n_cmp++;
    if (addr_log.size() != 3) begin
      n_err++;
      $display("FAIL prog_addr_count: reads=%0d, required 3", addr_log.size());
    end else begin
      n_cmp++;
      if (addr_log[0] !== 16'h8000 || addr_log[1] !== 16'h8001 || addr_log[2] !== 16'h8002) begin
        n_err++;
        $display("FAIL prog_addr: got %h %h %h, required 8000 8001 8002",
                 addr_log[0], addr_log[1], addr_log[2]);
      end
    end
    InstrReady = 1'b0;
    $display("test_program: accepted=%0d reads=%0d Halted=%b", acc_log.size(), addr_log.size(), Halted);
  endtask

  task automatic test_timing_backpressure();
    logic [31:0] held;
    do_reset();
    mem[0] = 32'h01020001; mem[1] = 32'hFF000000;
    addr_log.delete(); acc_log.delete();
    InstrReady = 1'b0;
    pulse_start();                       // edge E0 samples Start
    @(negedge clk);
    n_cmp++;
    if (nRead !== 1'b0 || address !== 16'h8000 || Busy !== 1'b1) begin
      n_err++;
      $display("FAIL timing_req: nRead=%b address=%h Busy=%b, required 0 / 8000 / 1", nRead, address, Busy);
    end
    tick();                              // E1
    @(negedge clk);
    n_cmp++;
    if (nRead !== 1'b1 || InstrValid !== 1'b0 || address !== 16'h8000) begin
      n_err++;
      $display("FAIL timing_wait: nRead=%b valid=%b address=%h, required 1 / 0 / 8000",
               nRead, InstrValid, address);
    end
    tick();                              // E2: capture
    @(negedge clk);
    n_cmp++;
    if (InstrValid !== 1'b1 || {Opcode, Dest, Src1, Src2} !== 32'h01020001) begin
      n_err++;
      $display("FAIL timing_valid: valid=%b word=%h, required 1 / 01020001",
               InstrValid, {Opcode, Dest, Src1, Src2});
    end
    held = {Opcode, Dest, Src1, Src2};
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (InstrValid !== 1'b1 || nRead !== 1'b1 || {Opcode, Dest, Src1, Src2} !== 32'h01020001) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b nRead=%b word=%h, required 1 / 1 / 01020001",
                 i, InstrValid, nRead, {Opcode, Dest, Src1, Src2});
      end
    end
    tick();
    InstrReady = 1'b1;
    tick();                              // acceptance edge
    InstrReady = 1'b0;
    wait_halt(40);
    @(negedge clk);
    n_cmp++;
    if (acc_log.size() != 1 || Halted !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: accepted=%0d Halted=%b, required 1 / 1", acc_log.size(), Halted);
    end
    n_cmp++;
    if (addr_log.size() != 2 || addr_log[addr_log.size()-1] !== 16'h8001) begin
      n_err++;
      $display("FAIL bp_reads: reads=%0d, required 2 ending at 8001", addr_log.size());
    end
    $display("test_timing_backpressure: held=%h accepted=%0d reads=%0d", held, acc_log.size(), addr_log.size());
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    mem2[0] = 32'h01000000; mem2[1] = 32'h02000000; mem2[2] = 32'h03000000;
    addr_log2.delete(); acc_log2.delete();
    InstrReady2 = 1'b1;
    Start2 = 1'b1; tick(); Start2 = 1'b0;
    n = 0;
    while (!Halted2 && n < 60) begin tick(); n++; end
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if (Overrun2 !== 1'b1 || Halted2 !== 1'b1 || IllegalOp2 !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_flags: Overrun=%b Halted=%b IllegalOp=%b, required 1 / 1 / 0",
               Overrun2, Halted2, IllegalOp2);
    end
    n_cmp++;
    if (acc_log2.size() != 2 || addr_log2.size() != 2) begin
      n_err++;
      $display("FAIL overrun_reads: accepted=%0d reads=%0d, required 2 / 2", acc_log2.size(), addr_log2.size());
    end else begin
      n_cmp++;
      if (addr_log2[1] !== 16'h8001 || acc_log2[1] !== 32'h02000000) begin
        n_err++;
        $display("FAIL overrun_last: addr=%h word=%h, required 8001 / 02000000", addr_log2[1], acc_log2[1]);
      end
    end
    // Restart from HALT clears the sticky flag
    InstrReady2 = 1'b0;
    Start2 = 1'b1; tick(); Start2 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (Overrun2 !== 1'b0 || Busy2 !== 1'b1 || address2 !== 16'h8000) begin
      n_err++;
      $display("FAIL overrun_restart: Overrun=%b Busy=%b address=%h, required 0 / 1 / 8000",
               Overrun2, Busy2, address2);
    end
    $display("test_overrun: accepted=%0d reads=%0d Overrun=%b", acc_log2.size(), addr_log2.size(), Overrun2);
  endtask

  task automatic test_reset_during_wait();
    do_reset();
    mem[0] = 32'h01020001; mem[1] = 32'hFF000000;
    InstrReady = 1'b0;
    pulse_start();                       // E0 -> REQ
    tick();                              // E1 -> WAIT
    Reset = 1'b1;
    tick();                              // would-be capture edge, reset wins
    Reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (address !== 16'h0000 || nRead !== 1'b1 || InstrValid !== 1'b0 ||
        {Opcode, Dest, Src1, Src2} !== 32'h0 || {Busy, Halted, Overrun, IllegalOp} !== 4'b0) begin
      n_err++;
      $display("FAIL rstwait_state: address=%h nRead=%b valid=%b word=%h BHOI=%b, required reset values",
               address, nRead, InstrValid, {Opcode, Dest, Src1, Src2}, {Busy, Halted, Overrun, IllegalOp});
    end
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if (InstrValid !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_idle: valid=%b Busy=%b, required 0 / 0", InstrValid, Busy);
    end
    addr_log.delete(); acc_log.delete();
    InstrReady = 1'b1;
    pulse_start();
    wait_halt(40);
    InstrReady = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (addr_log.size() < 1 || addr_log[0] !== 16'h8000 || acc_log.size() != 1 || acc_log[0] !== 32'h01020001) begin
      n_err++;
      $display("FAIL rstwait_refetch: reads=%0d accepted=%0d, required first read 8000 and word 01020001",
               addr_log.size(), acc_log.size());
    end
    $display("test_reset_during_wait: refetch reads=%0d accepted=%0d", addr_log.size(), acc_log.size());
  endtask

  task automatic test_opcode_check();
    do_reset();
    mem[0] = 32'h07000000; mem[1] = 32'hFF000000;
    acc_log.delete();
    seen_valid = 1'b0;
    InstrReady = 1'b1;
    pulse_start();
    wait_halt(40);
    InstrReady = 1'b0;
    @(negedge clk);
`ifdef IFETCH_OPCHECK_EN
    n_cmp++;
    if (IllegalOp !== 1'b1 || Halted !== 1'b1 || seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL opcheck_illegal: IllegalOp=%b Halted=%b seen_valid=%b, required 1 / 1 / 0",
               IllegalOp, Halted, seen_valid);
    end
`else
    n_cmp++;
    if (IllegalOp !== 1'b0 || Halted !== 1'b1 || acc_log.size() != 1 || acc_log[0] !== 32'h07000000) begin
      n_err++;
      $display("FAIL opcheck_off: IllegalOp=%b Halted=%b accepted=%0d, required 0 / 1 / one 07000000",
               IllegalOp, Halted, acc_log.size());
    end
`endif
    $display("test_opcode_check: IllegalOp=%b Halted=%b seen_valid=%b", IllegalOp, Halted, seen_valid);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 32'h0;
      mem2[i] = 32'h0;
    end
    test_reset();
    test_program();
    test_timing_backpressure();
    test_overrun();
    test_reset_during_wait();
    test_opcode_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
